// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: inst field positions,
// the idle instruction word, the sequencer state enum and the word builder.
package core_inst_pkg;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 8;

  localparam int BIT_ACC      = 33;
  localparam int BIT_CEN_P    = 32;
  localparam int BIT_WEN_P    = 31;
  localparam int A_P_LSB      = 20;
  localparam int BIT_CEN_X    = 19;
  localparam int BIT_WEN_X    = 18;
  localparam int A_X_LSB      = 7;
  localparam int BIT_OFIFO_RD = 6;
  localparam int BIT_IFIFO_WR = 5;
  localparam int BIT_IFIFO_RD = 4;
  localparam int BIT_L0_RD    = 3;
  localparam int BIT_L0_WR    = 2;
  localparam int BIT_EXEC     = 1;
  localparam int BIT_LOAD     = 0;

  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_LOAD, S_GAP, S_A_L0, S_EXEC, S_DRAIN, S_OFIFO, S_DONE
  } seq_state_e;

  typedef struct packed {
    logic              acc;
    logic              cen_p;
    logic              wen_p;
    logic [ADDR_W-1:0] a_p;
    logic              cen_x;
    logic              wen_x;
    logic [ADDR_W-1:0] a_x;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_f_t;

  function automatic logic [INST_W-1:0] build_inst(inst_f_t f);
    logic [INST_W-1:0] w;
    w                     = '0;
    w[BIT_ACC]            = f.acc;
    w[BIT_CEN_P]          = f.cen_p;
    w[BIT_WEN_P]          = f.wen_p;
    w[A_P_LSB +: ADDR_W]  = f.a_p;
    w[BIT_CEN_X]          = f.cen_x;
    w[BIT_WEN_X]          = f.wen_x;
    w[A_X_LSB +: ADDR_W]  = f.a_x;
    w[BIT_OFIFO_RD]       = f.ofifo_rd;
    w[BIT_IFIFO_WR]       = f.ififo_wr;
    w[BIT_IFIFO_RD]       = f.ififo_rd;
    w[BIT_L0_RD]          = f.l0_rd;
    w[BIT_L0_WR]          = f.l0_wr;
    w[BIT_EXEC]           = f.execute;
    w[BIT_LOAD]           = f.load;
    return w;
  endfunction

endpackage

// File: rtl/inst_phase_cnt.sv
// Loadable down-counter timing the fixed-length sequencer phases; tc marks the
// last cycle of a phase.
module inst_phase_cnt
  import core_inst_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '0);

endmodule

// File: rtl/core_inst_sequencer.sv
// Drives the core inst word through one kij pass: weight load, kernel load,
// activation load, execute and a flow-controlled OFIFO-to-pmem drain.
module core_inst_sequencer
  import core_inst_pkg::*;
#(
  parameter int          row       = 8,
  parameter int          col       = 8,
  parameter int          len_nij   = 36,
  parameter int          len_kij   = 9,
  parameter logic [10:0] w_base    = 11'h400,
  parameter int          rd_lat    = 1,
  parameter int          gap_cyc   = 12,
  parameter int          drain_cyc = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        kij,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CNT_W-1:0] COL_C   = CNT_W'(col);
  localparam logic [CNT_W-1:0] NIJ_C   = CNT_W'(len_nij);
  localparam logic [CNT_W-1:0] RDLAT_C = CNT_W'(rd_lat);
  localparam logic [3:0]       KIJ_C   = 4'(len_kij);

  // Array height does not affect instruction timing.
  logic [31:0] unused_row;
  assign unused_row = 32'(row);

  seq_state_e        state_q, state_d;
  logic [3:0]        kij_q, kij_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic              wr_pend_q, wr_pend_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic              cnt_load, cnt_tc;
  logic [CNT_W-1:0]  cnt_val, cnt, t, n_words;
  logic [ADDR_W-1:0] base;
  logic              rd_issue;
  inst_f_t           f;

  function automatic logic [CNT_W-1:0] phase_last(seq_state_e s);
    case (s)
      S_W_L0:  return CNT_W'(col + rd_lat - 1);
      S_LOAD:  return CNT_W'(3 * col - 1);
      S_GAP:   return CNT_W'(gap_cyc - 1);
      S_A_L0:  return CNT_W'(len_nij + rd_lat - 1);
      S_EXEC:  return CNT_W'(len_nij - 1);
      S_DRAIN: return CNT_W'(drain_cyc - 1);
      default: return '0;
    endcase
  endfunction

  inst_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  // NOTE: every output of this block gets a default first so no path leaves a
  // latch behind.
  always_comb begin
    state_d   = state_q;
    kij_d     = kij_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_pend_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_issue  = 1'b0;
    n_words   = NIJ_C;
    base      = '0;
    t         = phase_last(state_q) - cnt;
    f         = '0;
    f.cen_p   = 1'b1;
    f.wen_p   = 1'b1;
    f.cen_x   = 1'b1;
    f.wen_x   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (kij < KIJ_C) begin
            kij_d   = kij;
            state_d = S_W_L0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_W_L0, S_A_L0: begin
        if (state_q == S_W_L0) begin
          n_words = COL_C;
          base    = w_base;
        end
        if (t < n_words) begin
          f.cen_x = 1'b0;
          f.a_x   = base + ADDR_W'(t);
        end
        f.l0_wr = (t >= RDLAT_C);
        if (cnt_tc) state_d = (state_q == S_W_L0) ? S_LOAD : S_EXEC;
      end
      S_LOAD: begin
        f.load  = 1'b1;
        f.l0_rd = (t < COL_C);
        if (cnt_tc) state_d = S_GAP;
      end
      S_GAP: if (cnt_tc) state_d = S_A_L0;
      S_EXEC: begin
        f.execute = 1'b1;
        f.l0_rd   = 1'b1;
        if (cnt_tc) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_tc) begin
          state_d  = S_OFIFO;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      S_OFIFO: begin
        // A read issued this cycle becomes next cycle's pmem write.
        rd_issue   = ofifo_valid && (rd_cnt_q < NIJ_C);
        f.ofifo_rd = rd_issue;
        rd_cnt_d   = rd_cnt_q + CNT_W'(rd_issue);
        wr_pend_d  = rd_issue;
        if (wr_pend_q) begin
          f.cen_p  = 1'b0;
          f.wen_p  = 1'b0;
          f.a_p    = ADDR_W'(kij_q) * ADDR_W'(len_nij) + ADDR_W'(wr_cnt_q);
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == NIJ_C - 1'b1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cnt_load = (state_d != state_q);
    cnt_val  = phase_last(state_d);
    busy_d   = (state_q != S_IDLE);
    inst_d   = build_inst(f);
  end

  // NOTE: reset is sampled on the clock edge, so it only takes effect at the
  // next rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      kij_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      wr_pend_q <= 1'b0;
      inst_q    <= INST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q   <= state_d;
      kij_q     <= kij_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_pend_q <= wr_pend_d;
      inst_q    <= inst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: doc/core_inst_sequencer.md
# core_inst_sequencer

Hardware instruction sequencer that drives the core's 34-bit `inst` word for one kernel-position (kij) pass. It replaces the bench-side stimulus and is the initiator end of the core instruction interface. It presumes weights and activations are already resident in xmem. On a `start` pulse it issues, in order:

- weight xmem→L0 transfer
- kernel load into the PEs
- activation xmem→L0 transfer
- execution
- a flow-controlled OFIFO→pmem drain

It then pulses `done`.

## Interface
Parameters:
- `row`, 8, PE rows
- `col`, 8, PE columns / weight words per kij
- `len_nij`, 36, input-map pixels per pass
- `len_kij`, 9, legal kij count
- `w_base`, 11'h400, xmem base of weight words
- `rd_lat`, 1, xmem read latency (cycles from `inst` address to data at L0)
- `gap_cyc`, 12, idle cycles after kernel load
- `drain_cyc`, 16, idle cycles after execute (array flush)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request, sampled in IDLE only
- `kij`  in  4  kernel position, sampled with `start`
- `ofifo_valid`  in  1  core OFIFO has a word
- `inst`  out  34  registered core instruction word
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of pass
- `err`  out  1  one-cycle pulse when `start` carries `kij >= len_kij`

`inst` field layout:
- [33] acc
- [32] CEN_pmem
- [31] WEN_pmem
- [30:20] A_pmem
- [19] CEN_xmem
- [18] WEN_xmem
- [17:7] A_xmem
- [6] ofifo_rd
- [5] ififo_wr
- [4] ififo_rd
- [3] l0_rd
- [2] l0_wr
- [1] execute
- [0] load

## Operation
- Idle word `INST_IDLE`: CEN_pmem=WEN_pmem=CEN_xmem=WEN_xmem=1, all other bits 0, i.e. 34'h1_800C_0000. This block always drives acc, ififo_wr and ififo_rd as 0.
- States: IDLE → W_L0 → LOAD → GAP → A_L0 → EXEC → DRAIN → OFIFO → DONE → IDLE.
- A phase counter `t` is cleared on every state entry.
- IDLE: `inst` = INST_IDLE.
  - `start` with `kij < len_kij` latches kij and enters W_L0.
  - `start` with an illegal kij pulses `err` next cycle and stays in IDLE.
- W_L0 (`col+rd_lat` cycles):
  - CEN_xmem=0, WEN_xmem=1 while `t < col`, with A_xmem = `w_base+t`.
  - l0_wr=1 for `rd_lat <= t < col+rd_lat`.
- LOAD (`3*col` cycles): load=1; l0_rd=1 for `t < col`.
- GAP (`gap_cyc` cycles): INST_IDLE.
- A_L0 (`len_nij+rd_lat` cycles): same as W_L0 with base 0 and `len_nij` words.
- EXEC (`len_nij` cycles): execute=1, l0_rd=1.
- DRAIN (`drain_cyc` cycles): INST_IDLE.
- OFIFO:
  - ofifo_rd=1 in any cycle where `ofifo_valid`=1 and fewer than `len_nij` reads have been issued.
  - Each read produces, one cycle later, a pmem write: CEN_pmem=0, WEN_pmem=0, A_pmem = `kij*len_nij + n`, where `n` is the write count 0..len_nij-1.
  - Reads and writes overlap back-to-back.
  - Exit after the `len_nij`-th write has been issued.
- DONE: one cycle, `done`=1, `inst` = INST_IDLE.
- Address arithmetic: A_pmem is 11 bits; the maximum value 8*36+35 = 323 cannot wrap. A_xmem = w_base+7 stays below 11'h7FF.
- `start` while `busy` is ignored; no queueing and no err.
- If `ofifo_valid` stays low, OFIFO waits indefinitely. Only `reset` aborts.

## Timing
- `inst`, `busy`, `done` and `err` are all registered.
- Reset values: `inst` = INST_IDLE, `busy`=0, `done`=0, `err`=0, state = IDLE, counters = 0.
- Reset mid-pass: on the next edge `inst` returns to INST_IDLE, with no partial pmem write emitted afterwards.
- If `start` is sampled at edge 0, the first W_L0 word appears on `inst` after edge 1 and `busy` rises the same cycle.
- Phase lengths at default parameters, with `ofifo_valid` tied 1:
  - W_L0 9, LOAD 24, GAP 12, A_L0 37, EXEC 36, DRAIN 16.
  - OFIFO 37: 36 reads plus a trailing write.
  - `done` is high in cycle 172 after the start edge; `busy` falls in cycle 173.
- A pmem write always follows its ofifo_rd by exactly one cycle, including when ofifo_valid stalls.

## Structure
- Package `core_inst_pkg` holds:
  - inst bit-position constants and field widths
  - INST_IDLE
  - the state enum
  - a function that builds the `inst` word from field values
- The core and bench must import the same package.
- Sub-module `inst_phase_cnt`: a loadable down-counter with terminal-count flag, shared by all fixed-length phases. The OFIFO read/write counters stay in the top module.

## Test plan
- **Reset:** assert `reset` for 3 cycles mid-EXEC → `inst` = 34'h1_800C_0000 and `busy`=0 on the next cycle; no further pmem write.
- **Full pass, no stall:** `kij`=0, `ofifo_valid`=1 →
  - A_xmem sequence 0x400..0x407 in W_L0, 0..35 in A_L0;
  - exactly 8 + 36 l0_wr cycles;
  - A_pmem writes 0..35;
  - `done` in cycle 172.
- **Pass with kij=8 and a stalled OFIFO:** toggle `ofifo_valid` 1/0 every cycle → A_pmem writes 288..323 in order; exactly 36 writes; each write lands one cycle after its read; `done` after the 36th write.
- **Illegal kij:** `start` with `kij`=9 → `err` pulse, `busy` stays 0, `inst` unchanged.
- **start while busy:** pulse `start` during LOAD with a different kij → ignored; pmem base remains that of the original kij.
- **Back-to-back passes:** pulse `start` in the cycle after `done` → the second pass begins normally and cycle counts match the full-pass case.
